// File: rtl/control_types.sv
// Shared control-path types: PC source select, fetch FSM encoding and the NOP word.
package control_types;

    typedef enum logic {
        PC_FOUR = 1'b0,
        ALU_OUT = 1'b1
    } pc_ctrl;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE  = 2'd0;
    localparam fetch_state_t S_REQ   = 2'd1;
    localparam fetch_state_t S_HOLD  = 2'd2;
    localparam fetch_state_t S_FAULT = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection and misalignment detection for the fetch unit.
module pc_next
    import control_types::*;
(
    input  logic [31:0] i_pc,
    input  pc_ctrl      i_pc_sel,
    input  logic [31:0] i_alu_out,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    always_comb begin
        o_next_pc = i_pc + 32'd4;
        // Jump targets drop bit 0; bit 1 set means not word-aligned.
        if (i_pc_sel == ALU_OUT)
            o_next_pc = i_alu_out & ~32'd1;
        o_misaligned = o_next_pc[1];
    end

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: request a word, hold it until retired,
// then advance the PC; a misaligned target or a missing ack parks the unit in FAULT.
module inst_fetch
    import control_types::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        retire,
    input  pc_ctrl      pc_sel,
    input  logic [31:0] alu_out,
    output logic [31:0] pc,
    output logic [31:0] pc_four,
    output logic [4:0]  opcode,
    output logic [3:0]  inst,
    output logic [31:0] instr,
    output logic        instr_vld,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    fetch_state_t   r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_instr;
    logic           r_err;
    logic [31:0]    r_fetch_cnt;
    logic [TW-1:0]  r_to_cnt;

    logic [31:0]    w_next_pc;
    logic           w_misaligned;

    pc_next u_pc_next (
        .i_pc         (r_pc),
        .i_pc_sel     (pc_sel),
        .i_alu_out    (alu_out),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= NOP;
            r_err       <= 1'b0;
            r_fetch_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_REQ;
                    r_to_cnt <= '0;
                end
                S_REQ: begin
                    // Ack wins over the timeout on the last allowed cycle.
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_HOLD;
                    end else if (r_to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        r_state <= S_FAULT;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (retire) begin
                        r_pc        <= w_next_pc;
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                        r_to_cnt    <= '0;
                        if (w_misaligned) begin
                            r_state <= S_FAULT;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                default: r_state <= S_FAULT;
            endcase
        end
    end

    assign imem_req  = (r_state == S_REQ);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_four   = r_pc + 32'd4;
    assign opcode    = r_instr[6:2];
    assign inst      = {r_instr[30], r_instr[14:12]};
    assign instr     = r_instr;
    assign instr_vld = (r_state == S_HOLD);
    assign fetch_err = r_err;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, fetch/hold, retire paths, faults, timeout and counter wrap.
module tb_inst_fetch;
    import control_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        retire;
    pc_ctrl      pc_sel;
    logic [31:0] alu_out;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic [4:0]  opcode;
    logic [3:0]  inst;
    logic [31:0] instr;
    logic        instr_vld;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .retire     (retire),
        .pc_sel     (pc_sel),
        .alu_out    (alu_out),
        .pc         (pc),
        .pc_four    (pc_four),
        .opcode     (opcode),
        .inst       (inst),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .fetch_err  (fetch_err),
        .fetch_cnt  (fetch_cnt)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        retire = 1'b0; pc_sel = PC_FOUR; alu_out = '0;
        tick(2);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0h want 0", imem_req); end
        n_tests++; if (instr_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0h want 0", instr_vld); end
        n_tests++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h want 00000013", instr); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
        n_tests++; if (pc_four !== 32'h4) begin n_fail++; $display("FAIL reset_pc_four got %h want 4", pc_four); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0h want 0", fetch_err); end
        n_tests++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", fetch_cnt); end
    endtask

    task automatic test_basic_fetch;
        rst_n = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL req_after_reset got %0h want 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got %h want 0", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (instr_vld !== 1'b1) begin n_fail++; $display("FAIL hold_vld got %0h want 1", instr_vld); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got %0h want 0", imem_req); end
        n_tests++; if (opcode !== 5'b01100) begin n_fail++; $display("FAIL add_opcode got %b want 01100", opcode); end
        n_tests++; if (inst !== 4'b0000) begin n_fail++; $display("FAIL add_inst got %b want 0000", inst); end
        // Ack and new data while holding must not disturb the held word.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick(2);
        imem_ack = 1'b0;
        n_tests++; if (instr !== 32'h0000_0033) begin n_fail++; $display("FAIL hold_stable got %h want 00000033", instr); end
        n_tests++; if (instr_vld !== 1'b1) begin n_fail++; $display("FAIL hold_stable_vld got %0h want 1", instr_vld); end
    endtask

    task automatic test_retire_four;
        retire = 1'b1; pc_sel = PC_FOUR;
        tick();
        retire = 1'b0;
        n_tests++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL four_addr got %h want 4", imem_addr); end
        n_tests++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL four_cnt got %0d want 1", fetch_cnt); end
        n_tests++; if (instr_vld !== 1'b0) begin n_fail++; $display("FAIL four_vld got %0h want 0", instr_vld); end
        n_tests++; if (pc_four !== 32'h8) begin n_fail++; $display("FAIL four_pc_four got %h want 8", pc_four); end
        // Retire during REQ is ignored.
        retire = 1'b1; pc_sel = ALU_OUT; alu_out = 32'h0000_0200;
        tick();
        retire = 1'b0; pc_sel = PC_FOUR;
        n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL req_retire_pc got %h want 4", pc); end
        n_tests++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL req_retire_cnt got %0d want 1", fetch_cnt); end
    endtask

    task automatic test_back_to_back;
        imem_ack = 1'b1; imem_rdata = 32'h4000_5033;
        tick();
        n_tests++; if (inst !== 4'b1101) begin n_fail++; $display("FAIL sra_inst got %b want 1101", inst); end
        n_tests++; if (opcode !== 5'b01100) begin n_fail++; $display("FAIL sra_opcode got %b want 01100", opcode); end
        imem_ack = 1'b0; retire = 1'b1;
        tick();
        n_tests++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req got addr %h req %0h want addr 8 req 1", imem_addr, imem_req); end
        n_tests++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL b2b_cnt got %0d want 2", fetch_cnt); end
        retire = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (instr_vld !== 1'b1 || pc !== 32'h8) begin n_fail++; $display("FAIL b2b_hold got vld %0h pc %h want vld 1 pc 8", instr_vld, pc); end
        n_tests++; if (instr !== 32'h0000_0013) begin n_fail++; $display("FAIL b2b_instr got %h want 00000013", instr); end
    endtask

    task automatic test_branch_fault;
        retire = 1'b1; pc_sel = ALU_OUT; alu_out = 32'h0000_0101;
        tick();
        retire = 1'b0; pc_sel = PC_FOUR;
        n_tests++; if (pc !== 32'h0000_0100) begin n_fail++; $display("FAIL jump_pc got %h want 00000100", pc); end
        n_tests++; if (imem_addr !== 32'h0000_0100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL jump_req got addr %h req %0h want addr 100 req 1", imem_addr, imem_req); end
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL jump_err got %0h want 0", fetch_err); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        retire = 1'b1; pc_sel = ALU_OUT; alu_out = 32'h0000_0102;
        tick();
        retire = 1'b0; pc_sel = PC_FOUR;
        n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %0h want 1", fetch_err); end
        n_tests++; if (pc !== 32'h0000_0102) begin n_fail++; $display("FAIL misalign_pc got %h want 00000102", pc); end
        n_tests++; if (imem_req !== 1'b0 || instr_vld !== 1'b0) begin n_fail++; $display("FAIL misalign_state got req %0h vld %0h want 0 0", imem_req, instr_vld); end
        // FAULT is absorbing.
        imem_ack = 1'b1; retire = 1'b1;
        tick(3);
        imem_ack = 1'b0; retire = 1'b0;
        n_tests++; if (imem_req !== 1'b0 || instr_vld !== 1'b0 || fetch_err !== 1'b1) begin n_fail++; $display("FAIL fault_sticky got req %0h vld %0h err %0h want 0 0 1", imem_req, instr_vld, fetch_err); end
    endtask

    task automatic test_timeout;
        rst_n = 1'b0;
        tick();
        n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %0h want 0", fetch_err); end
        rst_n = 1'b1;
        tick();
        tick(15);
        n_tests++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL wait15_state got req %0h err %0h want 1 0", imem_req, fetch_err); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (instr_vld !== 1'b1 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL late_ack_hold got vld %0h err %0h want 1 0", instr_vld, fetch_err); end
        retire = 1'b1;
        tick();
        retire = 1'b0;
        tick(15);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL pre_timeout got req %0h addr %h want 1 4", imem_req, imem_addr); end
        tick();
        n_tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL timeout got err %0h req %0h want 1 0", fetch_err, imem_req); end
    endtask

    task automatic test_reset_mid_req;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++; if (imem_req !== 1'b0 || instr_vld !== 1'b0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL midreq_reset got req %0h vld %0h err %0h want 0 0 0", imem_req, instr_vld, fetch_err); end
        n_tests++; if (pc !== 32'h0 || fetch_cnt !== 32'h0 || instr !== 32'h0000_0013) begin n_fail++; $display("FAIL midreq_regs got pc %h cnt %h instr %h want 0 0 00000013", pc, fetch_cnt, instr); end
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5677;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (instr !== 32'h0000_0013 || instr_vld !== 1'b0) begin n_fail++; $display("FAIL stale_ack got instr %h vld %0h want 00000013 0", instr, instr_vld); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL refetch got req %0h addr %h want 1 0", imem_req, imem_addr); end
        tick();
        n_tests++; if (instr_vld !== 1'b0) begin n_fail++; $display("FAIL refetch_wait got vld %0h want 0", instr_vld); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (instr_vld !== 1'b1 || instr !== 32'h0000_0033) begin n_fail++; $display("FAIL refetch_hold got vld %0h instr %h want 1 00000033", instr_vld, instr); end
    endtask

    task automatic test_cnt_wrap;
        force dut.r_fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_cnt;
        retire = 1'b1; pc_sel = PC_FOUR;
        tick();
        retire = 1'b0;
        n_tests++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap got %h want 00000000", fetch_cnt); end
        n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL wrap_pc got %h want 4", pc); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_retire_four();
        test_back_to_back();
        test_branch_fault();
        test_timeout();
        test_reset_mid_req();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-002 Parameter ACK_TIMEOUT, default 16, is the maximum cycles waited for imem_ack before a fault.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  read data valid on imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 retire  input  1  downstream consumes the held instruction this cycle.
REQ-010 pc_sel  input  1  pc_ctrl from control_unit: PC_FOUR=0, ALU_OUT=1.
REQ-011 alu_out  input  32  branch/jump target.
REQ-012 pc  output  32  address of the held instruction.
REQ-013 pc_four  output  32  pc + 4, for writeback.
REQ-014 opcode  output  5  instr[6:2], to control_unit.
REQ-015 inst  output  4  {instr[30], instr[14:12]}, to control_unit.
REQ-016 instr  output  32  full held instruction word.
REQ-017 instr_vld  output  1  held instruction is valid.
REQ-018 fetch_err  output  1  sticky fault flag.
REQ-019 fetch_cnt  output  32  count of retired instructions.

Function
REQ-020 FSM states: IDLE, REQ, HOLD, FAULT.
REQ-021 IDLE → REQ unconditionally on the first clock with rst_n high; imem_addr=RESET_PC.
REQ-022 In REQ, imem_req=1 and imem_addr stay stable until imem_ack=1; data is captured into instr on that edge, then REQ → HOLD.
REQ-023 imem_ack outside REQ is ignored.
REQ-024 In HOLD, instr_vld=1 and imem_req=0; pc, instr, opcode and inst stay stable until retire=1.
REQ-025 On retire in HOLD: next = pc_sel ? {alu_out[31:1],1'b0} : pc+4; pc←next; HOLD→REQ; instr_vld=0 from the next cycle.
REQ-026 retire outside HOLD is ignored; pc_sel and alu_out are sampled only on the retire cycle.
REQ-027 If next[1]=1 on retire → FAULT instead of REQ; pc←next; fetch_err=1.
REQ-028 A timeout counter clears on entering REQ and increments each REQ cycle without ack; reaching ACK_TIMEOUT → FAULT, fetch_err=1.
REQ-029 FAULT is absorbing until reset: imem_req=0, instr_vld=0.
REQ-030 fetch_cnt increments by 1 on each accepted retire and wraps 32'hFFFF_FFFF → 0.
REQ-031 pc_four = pc+4 mod 2^32, combinational.
REQ-032 Minimum fetch latency: 1 cycle REQ (ack in the same cycle) + HOLD the next cycle; back-to-back retire gives 1 instruction per 2 cycles.

Reset
REQ-033 With rst_n=0 at a clock edge, the next state is: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_vld=0, imem_req=0, fetch_err=0, fetch_cnt=0, timeout counter=0.
REQ-034 Reset asserted mid-REQ abandons the request; a late imem_ack after reset is ignored unless the block is in the new REQ.

Structure
REQ-035 The fetch FSM state enum and the NOP constant belong in control_types, next to pc_ctrl.
REQ-036 The pc_sel input is of type pc_ctrl.
REQ-037 A single sub-module, pc_next, computes the next PC and the misalignment flag combinationally; everything else stays in inst_fetch.

Verification
REQ-038 Reset release, ack in the same cycle, rdata=32'h0000_0033 → imem_addr=0, HOLD next cycle, opcode=5'b01100, inst=4'b0000, instr_vld=1.
REQ-039 Retire with pc_sel=PC_FOUR at pc=0 → next imem_addr=4, fetch_cnt=1.
REQ-040 Retire with pc_sel=ALU_OUT, alu_out=32'h0000_0101 → pc=32'h0000_0100; alu_out=32'h0000_0102 → FAULT, fetch_err=1, imem_req stays 0.
REQ-041 Ack withheld for 16 cycles in REQ → FAULT; ack arriving at cycle 15 → normal HOLD.
REQ-042 rst_n=0 during REQ, then imem_ack on the following cycle → ignored, all outputs at reset values, refetch from RESET_PC.
REQ-043 fetch_cnt preloaded to 32'hFFFF_FFFF plus one retire → 0.
